// File: rtl/for_in_channel_engine.sv
// for_in_channel_engine: header emitter plus occupancy-driven drain loop.
// Input FIFO with valid/ready streaming in and out.
module for_in_channel_engine #(
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 8,
  parameter int HEADER     = 3,
  parameter int COUNT_MODE = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         finished,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                  out_count
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SIZE,
    POP,
    EMIT_CNT,
    EMIT_VAL,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             push, pop, hs, clr;
  logic [31:0]      k, k_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] val, val_n;
  logic [WIDTH-1:0] iter, iter_n;
  logic [WIDTH-1:0] data_n;
  logic             valid_n;

  assign in_ready = occupancy < OW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign busy     = !(state == IDLE || state == DONE);
  assign finished = (state == DONE);

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // FIFO storage; contents need no reset, pointers define validity
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= in_data;
  end

  // FIFO pointers and fill level
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else begin
      if (push) wptr <= bump(wptr);
      if (pop)  rptr <= bump(rptr);
      occupancy <= occupancy + OW'(push) - OW'(pop);
    end
  end

  // Sequencer state, registered output word and accepted-word count
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      cnt       <= '0;
      val       <= '0;
      iter      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      cnt       <= cnt_n;
      val       <= val_n;
      iter      <= iter_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      if (clr)     out_count <= '0;
      else if (hs) out_count <= out_count + 32'd1;
    end
  end

  // Next state; the output word is loaded one edge ahead of its state
  always_comb begin
    state_n = state;
    k_n     = k;
    cnt_n   = cnt;
    val_n   = val;
    iter_n  = iter;
    valid_n = out_valid;
    data_n  = out_data;
    pop     = 1'b0;
    clr     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          clr    = 1'b1;
          k_n    = '0;
          iter_n = '0;
          if (HEADER == 0) begin
            state_n = SIZE;
          end else begin
            state_n = HDR;
            valid_n = 1'b1;
            data_n  = WIDTH'(1);
          end
        end
      end
      HDR: begin
        if (hs) begin
          k_n = k + 32'd1;
          if (k_n == 32'(HEADER)) begin
            state_n = SIZE;
            valid_n = 1'b0;
          end else begin
            data_n = WIDTH'(k + 32'd2);
          end
        end
      end
      SIZE: begin
        cnt_n   = WIDTH'(occupancy);
        iter_n  = iter + WIDTH'(1);
        state_n = (occupancy == '0) ? DONE : POP;
      end
      POP: begin
        pop     = 1'b1;
        val_n   = mem[rptr];
        state_n = EMIT_CNT;
        valid_n = 1'b1;
        data_n  = (COUNT_MODE == 1) ? iter : cnt;
      end
      EMIT_CNT: begin
        if (hs) begin
          state_n = EMIT_VAL;
          data_n  = val;
        end
      end
      EMIT_VAL: begin
        if (hs) begin
          state_n = SIZE;
          valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
